// File: rtl/initialization_command_word_1_if.sv
// ---------------------------------------------------------------------------
// initialization_command_word_1_if
//
// Purpose:
//   Bundles the ICW1 write path from the 8259A bus-interface decoder with the
//   configuration fields that the ICW1 register returns to the control logic.
//
// Signals:
//   write_initial_command_word_1         ICW1 write strobe (decoder -> register)
//   internal_data_bus[7:0]               internal data bus byte D7..D0
//   interrupt_vector_address[2:0]        A7..A5 vector bits (from D7..D5)
//   level_or_edge_triggered_config       LTIM (from D3), 1 = level
//   call_address_interval_4_or_8_config  ADI  (from D2), 1 = interval 4
//   single_or_cascade_config             SNGL (from D1), 1 = single
//   set_icw4_config                      IC4  (from D0), 1 = ICW4 follows
//
// Modports:
//   master : the bus decoder / control logic side (drives strobe and data,
//            observes the configuration fields)
//   slave  : the ICW1 capture register
// ---------------------------------------------------------------------------
interface initialization_command_word_1_if;
  logic       write_initial_command_word_1;
  logic [7:0] internal_data_bus;
  logic [2:0] interrupt_vector_address;
  logic       level_or_edge_triggered_config;
  logic       call_address_interval_4_or_8_config;
  logic       single_or_cascade_config;
  logic       set_icw4_config;

  modport master (
    output write_initial_command_word_1,
    output internal_data_bus,
    input  interrupt_vector_address,
    input  level_or_edge_triggered_config,
    input  call_address_interval_4_or_8_config,
    input  single_or_cascade_config,
    input  set_icw4_config
  );

  modport slave (
    input  write_initial_command_word_1,
    input  internal_data_bus,
    output interrupt_vector_address,
    output level_or_edge_triggered_config,
    output call_address_interval_4_or_8_config,
    output single_or_cascade_config,
    output set_icw4_config
  );
endinterface

// File: rtl/initialization_command_word_1.sv
// ---------------------------------------------------------------------------
// initialization_command_word_1
//
// Purpose:
//   ICW1 capture register of the 8259A control-logic block. On an ICW1 write
//   strobe the internal data bus byte is latched into the initialization
//   configuration fields (vector address A7..A5, LTIM, ADI, SNGL, IC4). The
//   fields hold until the next ICW1 write or a reset. This is a load-enable
//   register bank with synchronous clear; there is no state machine.
//
// Ports:
//   clock     : system clock, all state changes on the rising edge
//   reset     : synchronous, active-high clear; wins over a same-edge write
//   icw1_bus  : initialization_command_word_1_if.slave
//                 in : write_initial_command_word_1, internal_data_bus[7:0]
//                 out: interrupt_vector_address[2:0],
//                      level_or_edge_triggered_config,
//                      call_address_interval_4_or_8_config,
//                      single_or_cascade_config, set_icw4_config
//
// Build option:
//   ICW1_D4_CHECK_EN : when defined, a strobe loads only if D4 (the ICW1
//                      identifier bit) is 1; otherwise every strobe loads.
//
// Timing:
//   Write-to-output and reset-to-output latency are both one clock. All
//   outputs come straight from flops.
// ---------------------------------------------------------------------------
module initialization_command_word_1 (
  input  logic                           clock,
  input  logic                           reset,
  initialization_command_word_1_if.slave icw1_bus
);

  // Bit positions of the ICW1 fields in the data byte.
  localparam int VEC_LSB  = 5;
  localparam int VEC_W    = 3;
  localparam int ID_BIT   = 4;
  localparam int LTIM_BIT = 3;
  localparam int ADI_BIT  = 2;
  localparam int SNGL_BIT = 1;
  localparam int IC4_BIT  = 0;

  logic             load_en;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             ltim_q, ltim_d;
  logic             adi_q, adi_d;
  logic             sngl_q, sngl_d;
  logic             ic4_q, ic4_d;

  // D4 identifies the byte as ICW1. The decoder already qualifies the strobe,
  // so by default D4 is ignored; the option adds a second-level check.
`ifdef ICW1_D4_CHECK_EN
  assign load_en = icw1_bus.write_initial_command_word_1 &
                   icw1_bus.internal_data_bus[ID_BIT];
`else
  assign load_en = icw1_bus.write_initial_command_word_1;
`endif

  // Next-state: load the bus fields when enabled, otherwise hold.
  generate
    for (genvar gi = 0; gi < VEC_W; gi++) begin : g_vec
      assign vector_d[gi] = load_en ? icw1_bus.internal_data_bus[VEC_LSB+gi]
                                    : vector_q[gi];
    end
  endgenerate

  assign ltim_d = load_en ? icw1_bus.internal_data_bus[LTIM_BIT] : ltim_q;
  assign adi_d  = load_en ? icw1_bus.internal_data_bus[ADI_BIT]  : adi_q;
  assign sngl_d = load_en ? icw1_bus.internal_data_bus[SNGL_BIT] : sngl_q;
  assign ic4_d  = load_en ? icw1_bus.internal_data_bus[IC4_BIT]  : ic4_q;

  // Reset is checked first so a same-edge write is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      vector_q <= '0;
      ltim_q   <= 1'b0;
      adi_q    <= 1'b0;
      sngl_q   <= 1'b0;
      ic4_q    <= 1'b0;
    end else begin
      vector_q <= vector_d;
      ltim_q   <= ltim_d;
      adi_q    <= adi_d;
      sngl_q   <= sngl_d;
      ic4_q    <= ic4_d;
    end
  end

  assign icw1_bus.interrupt_vector_address            = vector_q;
  assign icw1_bus.level_or_edge_triggered_config      = ltim_q;
  assign icw1_bus.call_address_interval_4_or_8_config = adi_q;
  assign icw1_bus.single_or_cascade_config            = sngl_q;
  assign icw1_bus.set_icw4_config                     = ic4_q;

endmodule

// File: tb/tb_initialization_command_word_1.sv
// ---------------------------------------------------------------------------
// tb_initialization_command_word_1
//
// Directed test of the ICW1 capture register. Expected values are written as
// {vector[2:0], LTIM, ADI, SNGL, IC4} and were decoded by hand from each byte.
// ---------------------------------------------------------------------------
module tb_initialization_command_word_1;

  logic clock = 1'b0;
  logic reset;
  int   checks_total  = 0;
  int   checks_passed = 0;

  initialization_command_word_1_if icw1_bus ();

  initialization_command_word_1 dut (
    .clock    (clock),
    .reset    (reset),
    .icw1_bus (icw1_bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] observed();
    return {icw1_bus.interrupt_vector_address,
            icw1_bus.level_or_edge_triggered_config,
            icw1_bus.call_address_interval_4_or_8_config,
            icw1_bus.single_or_cascade_config,
            icw1_bus.set_icw4_config};
  endfunction

  // Drive inputs away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic rst, input logic wr, input logic [7:0] data);
    @(negedge clock);
    reset                                 = rst;
    icw1_bus.write_initial_command_word_1 = wr;
    icw1_bus.internal_data_bus            = data;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] expected);
    logic [6:0] obs;
    obs = observed();
    checks_total++;
    assert (obs === expected) begin
      checks_passed++;
      $display("check %-14s observed=%b expected=%b ok", tag, obs, expected);
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, expected);
    end
  endtask

  initial begin
    reset                                 = 1'b0;
    icw1_bus.write_initial_command_word_1 = 1'b0;
    icw1_bus.internal_data_bus            = 8'h00;

    step(1'b1, 1'b0, 8'h00);  check("reset_init",   7'b000_0000);
    step(1'b0, 1'b1, 8'hFF);  check("write_ff_a",   7'b111_1111);
    step(1'b1, 1'b0, 8'h00);  check("reset_clears", 7'b000_0000);
    step(1'b0, 1'b1, 8'h00);  check("write_00",     7'b000_0000);
`ifdef ICW1_D4_CHECK_EN
    step(1'b0, 1'b1, 8'hAA);  check("write_aa",     7'b000_0000);
`else
    step(1'b0, 1'b1, 8'hAA);  check("write_aa",     7'b101_1010);
`endif
    step(1'b0, 1'b1, 8'hFF);  check("write_ff_b",   7'b111_1111);
    step(1'b0, 1'b0, 8'h00);  check("hold_00",      7'b111_1111);
    step(1'b0, 1'b0, 8'hAA);  check("hold_aa",      7'b111_1111);
    step(1'b0, 1'b0, 8'hFF);  check("hold_ff",      7'b111_1111);
    step(1'b0, 1'b1, 8'h35);  check("write_35",     7'b001_0101);
`ifdef ICW1_D4_CHECK_EN
    step(1'b0, 1'b1, 8'h4B);  check("write_4b",     7'b001_0101);
`else
    step(1'b0, 1'b1, 8'h4B);  check("write_4b",     7'b010_1011);
`endif
    // Strobe held for consecutive edges: every edge reloads, last byte wins.
    step(1'b0, 1'b1, 8'h1F);  check("burst_1f",     7'b000_1111);
    step(1'b0, 1'b1, 8'hF0);  check("burst_f0",     7'b111_0000);
    // Reset and write on the same edge: reset wins.
    step(1'b1, 1'b1, 8'hFF);  check("rst_and_wr",   7'b000_0000);
    step(1'b0, 1'b0, 8'hFF);  check("idle_after",   7'b000_0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
